// File: rtl/fifo_pkg.sv
// Shared sizing defaults and pointer-wrap helper for the FIFO control stage.
package fifo_pkg;

  localparam int unsigned MEM_SIZE_DEF = 4;
  localparam int unsigned PTR_L_DEF    = 2;
  localparam int unsigned CNT_L_DEF    = 3;

  // Next pointer value with explicit wrap at size-1 (size need not be a power of 2).
  function automatic int unsigned ptr_wrap_inc(input int unsigned ptr, input int unsigned size);
    if (ptr >= size - 32'd1) begin
      return 32'd0;
    end
    return ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer register with increment enable and synchronous reset.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int unsigned MEM_SIZE = MEM_SIZE_DEF,
  parameter int unsigned PTR_L    = PTR_L_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [PTR_L-1:0] ptr
);

  logic [PTR_L-1:0] ptr_q;
  logic [PTR_L-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc) begin
      ptr_d = PTR_L'(ptr_wrap_inc(32'(ptr_q), MEM_SIZE));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO control stage: qualifies push/pop requests, drives array pointers,
// tracks occupancy and reports status flags, read-valid and a sticky error.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned MEM_SIZE = MEM_SIZE_DEF,
  parameter int unsigned PTR_L    = PTR_L_DEF,
  parameter int unsigned CNT_L    = CNT_L_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_req,
  input  logic             pop_req,
  input  logic [CNT_L-1:0] almost_full_thr,
  input  logic [CNT_L-1:0] almost_empty_thr,
  output logic             push,
  output logic             pop,
  output logic [PTR_L-1:0] wr_ptr,
  output logic [PTR_L-1:0] rd_ptr,
  output logic [CNT_L-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic             valid_out,
  output logic             error
);

  logic [CNT_L-1:0] count_q;
  logic [CNT_L-1:0] count_d;
  logic             valid_q;
  logic             valid_d;
  logic             error_q;
  logic             error_d;
  logic             push_ok;
  logic             pop_ok;

  // Status flags are pure compares on the registered occupancy.
  always_comb begin
    empty        = (count_q == '0);
    full         = (count_q == CNT_L'(MEM_SIZE));
    almost_empty = (count_q <= almost_empty_thr);
    almost_full  = (count_q >= almost_full_thr);
  end

  // Reset masks both strobes so nothing reaches the array on the reset edge.
  always_comb begin
    pop_ok  = ~reset & pop_req & ~empty;
    push_ok = ~reset & push_req & (~full | pop_ok);
  end

  always_comb begin
    count_d = count_q;
    valid_d = pop_ok;
    error_d = error_q | (push_req & ~push_ok) | (pop_req & ~pop_ok);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_L'(1);
      2'b01:   count_d = count_q - CNT_L'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      count_q <= count_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  fifo_ptr #(
    .MEM_SIZE (MEM_SIZE),
    .PTR_L    (PTR_L)
  ) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (push_ok),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(
    .MEM_SIZE (MEM_SIZE),
    .PTR_L    (PTR_L)
  ) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (pop_ok),
    .ptr   (rd_ptr)
  );

  assign push      = push_ok;
  assign pop       = pop_ok;
  assign count     = count_q;
  assign valid_out = valid_q;
  assign error     = error_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: directed vector table, hand-written
// reset-during-pop sequence, and randomized traffic against a queue model.
module tb_fifo_ctrl;

  localparam int unsigned MEM_SIZE = 4;
  localparam int unsigned PTR_L    = 2;
  localparam int unsigned CNT_L    = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             push_req;
  logic             pop_req;
  logic [CNT_L-1:0] almost_full_thr;
  logic [CNT_L-1:0] almost_empty_thr;
  logic             push;
  logic             pop;
  logic [PTR_L-1:0] wr_ptr;
  logic [PTR_L-1:0] rd_ptr;
  logic [CNT_L-1:0] count;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic             valid_out;
  logic             error;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_ctrl #(
    .MEM_SIZE (MEM_SIZE),
    .PTR_L    (PTR_L),
    .CNT_L    (CNT_L)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .push_req         (push_req),
    .pop_req          (pop_req),
    .almost_full_thr  (almost_full_thr),
    .almost_empty_thr (almost_empty_thr),
    .push             (push),
    .pop              (pop),
    .wr_ptr           (wr_ptr),
    .rd_ptr           (rd_ptr),
    .count            (count),
    .empty            (empty),
    .full             (full),
    .almost_empty     (almost_empty),
    .almost_full      (almost_full),
    .valid_out        (valid_out),
    .error            (error)
  );

  typedef struct {
    logic rst, pu, po;
    logic e_push, e_pop;
    int   e_wr, e_rd, e_cnt;
    logic e_empty, e_full, e_ae, e_af, e_vld, e_err;
  } vec_t;

  vec_t tbl[14];

  // Behavioural model: a queue of tokens plus modular pointers.
  int mq[$];
  int m_wr, m_rd, m_tok;
  bit m_err, m_vld;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, ".push"},         32'(push),         32'(v.e_push));
    chk({tag, ".pop"},          32'(pop),          32'(v.e_pop));
    chk({tag, ".wr_ptr"},       32'(wr_ptr),       32'(v.e_wr));
    chk({tag, ".rd_ptr"},       32'(rd_ptr),       32'(v.e_rd));
    chk({tag, ".count"},        32'(count),        32'(v.e_cnt));
    chk({tag, ".empty"},        32'(empty),        32'(v.e_empty));
    chk({tag, ".full"},         32'(full),         32'(v.e_full));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(v.e_ae));
    chk({tag, ".almost_full"},  32'(almost_full),  32'(v.e_af));
    chk({tag, ".valid_out"},    32'(valid_out),    32'(v.e_vld));
    chk({tag, ".error"},        32'(error),        32'(v.e_err));
  endtask

  function automatic vec_t mk(input logic rst, pu, po, e_push, e_pop,
                              input int e_wr, e_rd, e_cnt,
                              input logic e_empty, e_full, e_ae, e_af, e_vld, e_err);
    vec_t v;
    v.rst = rst; v.pu = pu; v.po = po;
    v.e_push = e_push; v.e_pop = e_pop;
    v.e_wr = e_wr; v.e_rd = e_rd; v.e_cnt = e_cnt;
    v.e_empty = e_empty; v.e_full = e_full; v.e_ae = e_ae; v.e_af = e_af;
    v.e_vld = e_vld; v.e_err = e_err;
    return v;
  endfunction

  // Drive inputs just after a rising edge, then sample at the falling edge.
  task automatic drive(input logic r, input logic pu, input logic po);
    reset    = r;
    push_req = pu;
    pop_req  = po;
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycle(input logic r, input logic pu, input logic po);
    drive(r, pu, po);
    advance();
  endtask

  function automatic vec_t model_expect(input logic r, input logic pu, input logic po);
    vec_t v;
    int   n;
    bit   p_ok, u_ok;
    n    = mq.size();
    p_ok = !r && po && (n > 0);
    u_ok = !r && pu && ((n < MEM_SIZE) || p_ok);
    v.rst = r; v.pu = pu; v.po = po;
    v.e_push  = u_ok;
    v.e_pop   = p_ok;
    v.e_wr    = m_wr;
    v.e_rd    = m_rd;
    v.e_cnt   = n;
    v.e_empty = (n == 0);
    v.e_full  = (n == MEM_SIZE);
    v.e_ae    = (n <= int'(almost_empty_thr));
    v.e_af    = (n >= int'(almost_full_thr));
    v.e_vld   = m_vld;
    v.e_err   = m_err;
    return v;
  endfunction

  task automatic model_update(input logic r, input logic pu, input logic po);
    int n;
    bit p_ok, u_ok;
    if (r) begin
      mq.delete();
      m_wr = 0; m_rd = 0; m_err = 0; m_vld = 0;
      return;
    end
    n    = mq.size();
    p_ok = po && (n > 0);
    u_ok = pu && ((n < MEM_SIZE) || p_ok);
    if (p_ok) begin
      void'(mq.pop_front());
      m_rd = (m_rd + 1) % MEM_SIZE;
    end
    if (u_ok) begin
      mq.push_back(m_tok++);
      m_wr = (m_wr + 1) % MEM_SIZE;
    end
    if ((pu && !u_ok) || (po && !p_ok)) m_err = 1;
    m_vld = p_ok;
  endtask

  initial begin
    reset            = 1'b1;
    push_req         = 1'b0;
    pop_req          = 1'b0;
    almost_full_thr  = CNT_L'(3);
    almost_empty_thr = CNT_L'(1);
    m_tok            = 0;

    //           rst pu po  psh pop  wr rd cnt  emp ful ae af vld err
    tbl[0]  = mk(0, 0, 0,   0,  0,   0, 0, 0,   1,  0,  1, 0, 0,  0);
    tbl[1]  = mk(0, 1, 0,   1,  0,   0, 0, 0,   1,  0,  1, 0, 0,  0);
    tbl[2]  = mk(0, 1, 0,   1,  0,   1, 0, 1,   0,  0,  1, 0, 0,  0);
    tbl[3]  = mk(0, 1, 0,   1,  0,   2, 0, 2,   0,  0,  0, 0, 0,  0);
    tbl[4]  = mk(0, 1, 0,   1,  0,   3, 0, 3,   0,  0,  0, 1, 0,  0);
    tbl[5]  = mk(0, 1, 0,   0,  0,   0, 0, 4,   0,  1,  0, 1, 0,  0);
    tbl[6]  = mk(0, 1, 1,   1,  1,   0, 0, 4,   0,  1,  0, 1, 0,  1);
    tbl[7]  = mk(0, 1, 1,   1,  1,   1, 1, 4,   0,  1,  0, 1, 1,  1);
    tbl[8]  = mk(0, 1, 1,   1,  1,   2, 2, 4,   0,  1,  0, 1, 1,  1);
    tbl[9]  = mk(0, 0, 0,   0,  0,   3, 3, 4,   0,  1,  0, 1, 1,  1);
    tbl[10] = mk(0, 0, 0,   0,  0,   3, 3, 4,   0,  1,  0, 1, 0,  1);
    tbl[11] = mk(1, 1, 1,   0,  0,   3, 3, 4,   0,  1,  0, 1, 0,  1);
    tbl[12] = mk(0, 1, 1,   1,  0,   0, 0, 0,   1,  0,  1, 0, 0,  0);
    tbl[13] = mk(0, 0, 0,   0,  0,   1, 0, 1,   0,  0,  1, 0, 0,  1);

    run_cycle(1, 0, 0);
    run_cycle(1, 0, 0);

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rst, tbl[i].pu, tbl[i].po);
      chk_all($sformatf("tbl%0d", i), tbl[i]);
      advance();
    end

    // almost_full with a zero threshold is set even when empty.
    run_cycle(1, 0, 0);
    almost_full_thr = CNT_L'(0);
    drive(0, 0, 0);
    chk("af_thr0.almost_full", 32'(almost_full), 32'd1);
    chk("af_thr0.empty", 32'(empty), 32'd1);
    advance();
    almost_full_thr = CNT_L'(3);

    // Reach count=2 with rd_ptr=3, pop once, then reset with pop_req held.
    for (int i = 0; i < 3; i++) run_cycle(0, 1, 0);
    for (int i = 0; i < 3; i++) run_cycle(0, 0, 1);
    for (int i = 0; i < 2; i++) run_cycle(0, 1, 0);
    drive(0, 0, 1);
    chk("rstpop.pre_count", 32'(count), 32'd2);
    chk("rstpop.pre_rd", 32'(rd_ptr), 32'd3);
    chk("rstpop.pop", 32'(pop), 32'd1);
    advance();
    drive(1, 0, 1);
    chk("rstpop.rd_wrap", 32'(rd_ptr), 32'd0);
    chk("rstpop.count1", 32'(count), 32'd1);
    chk("rstpop.pop_masked", 32'(pop), 32'd0);
    chk("rstpop.valid_pending", 32'(valid_out), 32'd1);
    advance();
    drive(0, 0, 0);
    chk("rstpop.post_rd", 32'(rd_ptr), 32'd0);
    chk("rstpop.post_count", 32'(count), 32'd0);
    chk("rstpop.post_valid", 32'(valid_out), 32'd0);
    chk("rstpop.post_error", 32'(error), 32'd0);
    advance();

    // Randomized traffic with live thresholds, checked against the queue model.
    run_cycle(1, 0, 0);
    model_update(1, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      logic r, pu, po;
      vec_t exp_v;
      r  = ($urandom_range(0, 79) == 0);
      pu = ($urandom_range(0, 99) < 55);
      po = ($urandom_range(0, 99) < 50);
      almost_full_thr  = CNT_L'($urandom_range(0, 7));
      almost_empty_thr = CNT_L'($urandom_range(0, 7));
      drive(r, pu, po);
      exp_v = model_expect(r, pu, po);
      chk_all($sformatf("rnd%0d", c), exp_v);
      advance();
      model_update(r, pu, po);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
